// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: state encoding and word geometry shared by the ROM boot loader
package rom_loader_pkg;
  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
endpackage

// File: rtl/rom_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes, one-cycle word_valid
module byte_packer
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);
  logic [1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d, word_q, word_d;
  logic valid_q, valid_d;
  logic last;
  // shift each byte in from the top so the first byte lands in bits [7:0]
  always_comb begin
    last = byte_en && cnt_q == 2'(BYTES_PER_WORD - 1);
    sh_d = byte_en ? {byte_data, sh_q[WORD_W-1:8]} : sh_q;
    cnt_d = clear ? 2'd0 : byte_en ? cnt_q + 2'd1 : cnt_q;
    word_d = last ? sh_d : word_q;
    valid_d = last && !clear;
  end
  // packer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      word_q <= word_d;
      valid_q <= valid_d;
    end
  end
  assign word_valid = valid_q;
  assign word = word_q;
endmodule

// File: rtl/rom_loader.sv
// rom_loader: byte-stream ROM writer holding the CPU in reset until loaded; LOADER_CSUM_EN adds a trailing checksum
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid_in,
  input  logic [7:0]        byte_data_in,
  output logic              byte_ready_out,
  input  logic              start_in,
  output logic              rom_wen_out,
  output logic [ADDR_W-1:0] rom_waddr_out,
  output logic [31:0]       rom_wdata_out,
  output logic              cpu_run_out,
  output logic              err_out,
  output logic [ADDR_W:0]   words_loaded_out
);
`ifdef LOADER_CSUM_EN
  localparam state_e S_TAIL = S_CSUM;
  logic [WORD_W-1:0] sum_q, sum_d;
`else
  localparam state_e S_TAIL = S_DONE;
`endif
  state_e state_q, state_d;
  logic [ADDR_W:0] word_cnt_q, word_cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, word;
  logic word_valid, accept, restart;
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_en    (accept),
    .byte_data  (byte_data_in),
    .word_valid (word_valid),
    .word       (word)
  );
  assign byte_ready_out = !rst && (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM);
  assign accept = byte_valid_in && byte_ready_out;
  assign restart = start_in && (state_q == S_DONE || state_q == S_ERR);
  assign rom_wen_out = word_valid && state_q == S_DATA;
  assign rom_waddr_out = rom_wen_out ? word_cnt_q[ADDR_W-1:0] : waddr_q;
  assign rom_wdata_out = rom_wen_out ? word : wdata_q;
  assign cpu_run_out = state_q == S_DONE;
  assign err_out = state_q == S_ERR;
  assign words_loaded_out = word_cnt_q;
  // sequencing: length word, data words written as they complete, optional checksum, then done/error
  always_comb begin
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    len_d = len_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CSUM_EN
    sum_d = sum_q;
`endif
    if (state_q == S_LEN && word_valid) begin
      len_d = word[ADDR_W:0];
      state_d = word == '0 ? S_TAIL : word > WORD_W'(DEPTH) ? S_ERR : S_DATA;
    end
    if (rom_wen_out) begin
      waddr_d = word_cnt_q[ADDR_W-1:0];
      wdata_d = word;
      word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
`ifdef LOADER_CSUM_EN
      sum_d = sum_q + word;
`endif
      if (word_cnt_d == len_q) state_d = S_TAIL;
    end
`ifdef LOADER_CSUM_EN
    if (state_q == S_CSUM && word_valid) state_d = word == sum_q ? S_DONE : S_ERR;
`endif
    if (restart) begin
      state_d = S_LEN;
      word_cnt_d = '0;
`ifdef LOADER_CSUM_EN
      sum_d = '0;
`endif
    end
  end
  // loader state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN;
      word_cnt_q <= '0;
      len_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef LOADER_CSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q <= len_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized self-checking bench for rom_loader (DEPTH=16), LOADER_CSUM_EN aware
module tb_rom_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic byte_valid_in = 1'b0;
  logic [7:0] byte_data_in = '0;
  logic start_in = 1'b0;
  logic byte_ready_out, rom_wen_out, cpu_run_out, err_out;
  logic [3:0] rom_waddr_out;
  logic [31:0] rom_wdata_out;
  logic [4:0] words_loaded_out;
  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  logic [31:0] img[$];

  rom_loader #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .byte_valid_in    (byte_valid_in),
    .byte_data_in     (byte_data_in),
    .byte_ready_out   (byte_ready_out),
    .start_in         (start_in),
    .rom_wen_out      (rom_wen_out),
    .rom_waddr_out    (rom_waddr_out),
    .rom_wdata_out    (rom_wdata_out),
    .cpu_run_out      (cpu_run_out),
    .err_out          (err_out),
    .words_loaded_out (words_loaded_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rom_wen_out === 1'b1) wen_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid_in = 1'b1;
    byte_data_in = b;
    while (byte_ready_out !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%b want=1", byte_ready_out);
    end
    @(posedge clk);
    #1 byte_valid_in = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (byte_ready_out !== 1'b0 || rom_wen_out !== 1'b0 || rom_waddr_out !== 4'd0 ||
        rom_wdata_out !== 32'd0 || cpu_run_out !== 1'b0 || err_out !== 1'b0 || words_loaded_out !== 5'd0) begin
      errors++;
      $display("FAIL %s got rdy=%b wen=%b addr=%h data=%h run=%b err=%b wl=%0d want all 0",
               name, byte_ready_out, rom_wen_out, rom_waddr_out, rom_wdata_out, cpu_run_out, err_out, words_loaded_out);
    end
  endtask

  // one complete load of image img with length len; corrupt spoils the checksum when it exists
  task automatic run_load(input logic [31:0] len, input int gap, input bit corrupt);
    int nd;
    int w0;
    bit tail;
    bit exp_ok;
    logic [31:0] ln;
    logic [31:0] wd;
`ifdef LOADER_CSUM_EN
    logic [31:0] cs = 32'd0;
`endif
    ln = len;
    nd = (len <= 32'd16) ? int'(len) : 0;
    exp_ok = len <= 32'd16;
    pulse_start();
    checks++;
    if (err_out !== 1'b0 || cpu_run_out !== 1'b0 || words_loaded_out !== 5'd0 || byte_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL restart got err=%b run=%b wl=%0d rdy=%b want 0 0 0 1", err_out, cpu_run_out, words_loaded_out, byte_ready_out);
    end
    w0 = wen_cnt;
    for (int b = 0; b < 4; b++) send_byte(ln[8*b +: 8], gap);
    for (int i = 0; i < nd; i++) begin
      wd = img[i];
`ifdef LOADER_CSUM_EN
      cs = cs + wd;
`endif
      for (int b = 0; b < 4; b++) send_byte(wd[8*b +: 8], gap);
      @(negedge clk);
      checks++;
      if (rom_wen_out !== 1'b1 || rom_waddr_out !== 4'(i) || rom_wdata_out !== wd) begin
        errors++;
        $display("FAIL write%0d got wen=%b addr=%h data=%h want 1 %h %h", i, rom_wen_out, rom_waddr_out, rom_wdata_out, 4'(i), wd);
      end
    end
    tail = nd == 0;
`ifdef LOADER_CSUM_EN
    if (exp_ok) begin
      if (corrupt) begin
        cs = cs + 32'd1;
        exp_ok = 1'b0;
      end
      for (int b = 0; b < 4; b++) send_byte(cs[8*b +: 8], gap);
      tail = 1'b1;
    end
`endif
    if (tail) @(negedge clk);
    checks++;
    if (cpu_run_out !== 1'b0) begin
      errors++;
      $display("FAIL run_early got=%b want=0", cpu_run_out);
    end
    @(negedge clk);
    checks++;
    if (cpu_run_out !== exp_ok || err_out !== !exp_ok || byte_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL final got run=%b err=%b rdy=%b want %b %b 0", cpu_run_out, err_out, byte_ready_out, exp_ok, !exp_ok);
    end
    checks++;
    if (words_loaded_out !== 5'(nd) || wen_cnt - w0 != nd) begin
      errors++;
      $display("FAIL count got wl=%0d writes=%0d want %0d", words_loaded_out, wen_cnt - w0, nd);
    end
    if (nd > 0) begin
      checks++;
      if (rom_waddr_out !== 4'(nd - 1) || rom_wdata_out !== img[nd-1]) begin
        errors++;
        $display("FAIL hold got addr=%h data=%h want %h %h", rom_waddr_out, rom_wdata_out, 4'(nd - 1), img[nd-1]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1", byte_ready_out);
    end
  endtask

  task automatic test_basic();
    img = '{32'h00100013, 32'h00200093};
    run_load(32'd2, 0, 1'b0);
  endtask

  task automatic test_gapped();
    img = '{32'h00100013, 32'h00200093};
    run_load(32'd2, 3, 1'b0);
  endtask

  task automatic test_zero();
    img = {};
    run_load(32'd0, 0, 1'b0);
  endtask

  task automatic test_oversize();
    img = {};
    run_load(32'h11, 0, 1'b0);
    img = '{$urandom};
    run_load(32'd1, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    img = '{$urandom, $urandom, $urandom, $urandom};
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(8'(b == 0 ? 4 : 0), 0);
    for (int k = 0; k < 6; k++) begin
      wd = img[k / 4];
      send_byte(wd[8*(k%4) +: 8], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_mid");
    rst = 1'b0;
    img = '{$urandom};
    run_load(32'd1, 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? 16 : int'($urandom_range(1, 16));
      img = {};
      for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load(32'(n), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

`ifdef LOADER_CSUM_EN
  task automatic test_csum();
    img = '{32'd1, 32'd2};
    run_load(32'd2, 0, 1'b0);
    run_load(32'd2, 1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_zero();
    test_oversize();
    test_reset_mid();
    test_random();
`ifdef LOADER_CSUM_EN
    test_csum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Runtime writer for the instruction ROM. It replaces the simulation-only $readmemh preload with a synthesizable byte-stream boot path.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes the words into ROM starting at address 0.
- Holds the CPU in reset until loading completes.
- Sits between a host byte source (UART RX / debug port) and the write port of rom + the rst input of cpu.

Parameters:
- ADDR_W, 12, ROM word-address width.
- DEPTH, 4096, ROM capacity in 32-bit words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- byte_valid_in  input  1  source presents byte.
- byte_data_in  input  8  byte value.
- byte_ready_out  output  1  loader can accept the byte; transfer occurs when valid&&ready at posedge clk.
- start_in  input  1  single-cycle pulse; restarts a load from DONE or ERR.
- rom_wen_out  output  1  ROM write strobe, one cycle per word.
- rom_waddr_out  output  ADDR_W  ROM word address.
- rom_wdata_out  output  32  ROM write data.
- cpu_run_out  output  1  1 = release CPU (drives CPU active-low rst directly); 0 = hold CPU in reset.
- err_out  output  1  sticky load error.
- words_loaded_out  output  ADDR_W+1  count of words written this load.

Behaviour:
Reset:
- Clock clk; reset rst is synchronous and active-high.
- While rst=1 at a posedge, all state is cleared: state=S_LEN, byte_cnt=0, word_cnt=0, and all outputs 0 (byte_ready_out=0 during reset).
- A reset asserted mid-load aborts the load. cpu_run_out stays 0, and partially written ROM contents are left as-is.

States:
- S_LEN: byte_ready_out=1. Collects 4 bytes into a 32-bit length N, LSB first.
  - On the 4th byte: if N==0, go to S_DONE (or S_CSUM if the option is enabled). If N>DEPTH, go to S_ERR. Otherwise go to S_DATA.
- S_DATA: byte_ready_out=1. Collects 4 bytes per word, LSB first.
  - On the 4th accepted byte, the next cycle has rom_wen_out=1, rom_waddr_out=word_cnt[ADDR_W-1:0], rom_wdata_out=assembled word. word_cnt then increments.
  - byte_ready_out stays high on the write cycle (no bubble); a new byte may be accepted concurrently.
  - After word N is written, go to S_DONE.
- S_DONE: byte_ready_out=0, cpu_run_out=1 from the cycle after the last write onward.
- S_ERR: byte_ready_out=0, err_out=1, cpu_run_out=0.
- start_in in S_DONE or S_ERR: next state S_LEN. Clears cpu_run_out, err_out, word_cnt, byte_cnt. start_in is ignored in S_LEN and S_DATA.

Other rules:
- Bytes with byte_valid_in=0 do not advance byte_cnt. Gaps of any length are legal.
- words_loaded_out = word_cnt. It saturates at DEPTH by construction, since N<=DEPTH.
- rom_waddr_out and rom_wdata_out hold their last values when rom_wen_out=0.
- No ROM write ever targets an address >= N.

Optional Feature:
- Macro LOADER_CSUM_EN.
- With it defined:
  - A 4-byte checksum word follows the data, handled in state S_CSUM (ready=1).
  - The expected value is the mod-2^32 sum of the N data words.
  - Match: go to S_DONE. Mismatch: go to S_ERR, with cpu_run_out held at 0.
  - N==0 requires checksum 0x00000000.
- Without it: no S_CSUM state and no accumulator. S_DATA goes directly to S_DONE.

Decomposition:
- Shared package holds:
  - state encoding constants S_LEN=0, S_DATA=1, S_CSUM=2, S_DONE=3, S_ERR=4 (3-bit);
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- One natural sub-module, byte_packer: 2-bit byte counter plus 32-bit little-endian shift/assemble register. It emits word_valid for one cycle with the word, and has a clear input used on start/reset.
- FSM, address counter and checksum stay in rom_loader.

Test Plan:
1. Basic load:
   - Stimulus: bytes 02 00 00 00, 13 00 10 00, 93 00 20 00 streamed back-to-back.
   - Expected: rom writes addr0=0x00100013, addr1=0x00200093, each one cycle after its 4th byte; cpu_run_out=1 after the 2nd write; words_loaded_out=2; byte_ready_out=0.
2. Gapped valid:
   - Stimulus: same stream with byte_valid_in deasserted 3 cycles between every byte.
   - Expected: identical writes and data.
3. Zero length:
   - Stimulus: length 00 00 00 00.
   - Expected: no rom_wen_out; cpu_run_out=1 on the next cycle (without LOADER_CSUM_EN).
4. Oversize:
   - Stimulus: DEPTH=16, length 0x11.
   - Expected: err_out=1, cpu_run_out=0, byte_ready_out=0, no writes. Then a start_in pulse gives err_out=0 and a new load of length 1 succeeds.
5. Reset mid-load:
   - Stimulus: rst=1 after 1.5 words of a 4-word load.
   - Expected: all outputs 0. Reloading a fresh 1-word image writes addr0 and asserts cpu_run_out.
6. LOADER_CSUM_EN:
   - Stimulus: words 1 and 2. Checksum 0x00000003 → S_DONE with cpu_run_out=1. Checksum 0x00000004 → err_out=1, cpu_run_out=0, both words still written.
